// File: rtl/mc_maindec.sv
// Multicycle main control FSM: sequences fetch/decode/execute/writeback and counts retired instructions.
// Optional ORI support is enabled by defining MC_MAINDEC_ORI_EN.
module mc_maindec #(
    parameter int OP_W     = 6,
    parameter int CNT_W    = 16,
    parameter int WAIT_MEM = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [OP_W-1:0]  op,
    input  logic             mem_ready,
    output logic             iord,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             alusrca,
    output logic             branch,
    output logic             pcwrite,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             illegal_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    // state   | meaning
    // FETCH   | read instruction, PC+4 (waits on memory)
    // DECODE  | register read, branch target, dispatch on op
    // MEMADR  | load/store address calculation
    // MEMRD   | data read (waits on memory)
    // MEMWB   | load writeback
    // MEMWR   | data write (waits on memory)
    // EXECUTE | R-type ALU operation
    // ALUWB   | R-type writeback
    // BRANCH  | compare and conditional PC update
    // ADDIEX  | immediate add
    // ADDIWB  | immediate writeback (shared by ORI)
    // JUMP    | PC <- jump target
    // ORIEX   | immediate OR (optional)
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDIEX  = 4'd9;
    localparam logic [3:0] S_ADDIWB  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_ORIEX   = 4'd12;

    logic [3:0] state, state_next;
    logic       rdy;
    logic [5:0] op_lo;
    logic       op_hi_ok;
    logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j, is_ori, legal;
    logic       irwrite_raw, pcwrite_raw, regwrite_raw, memwrite_raw;

    assign rdy      = (WAIT_MEM == 0) ? 1'b1 : mem_ready;
    assign op_lo    = op[5:0];
    assign op_hi_ok = ((op >> 6) == '0);

    assign is_r    = op_hi_ok && (op_lo == 6'b000000);
    assign is_lw   = op_hi_ok && (op_lo == 6'b100011);
    assign is_sw   = op_hi_ok && (op_lo == 6'b101011);
    assign is_beq  = op_hi_ok && (op_lo == 6'b000100);
    assign is_addi = op_hi_ok && (op_lo == 6'b001000);
    assign is_j    = op_hi_ok && (op_lo == 6'b000010);
`ifdef MC_MAINDEC_ORI_EN
    assign is_ori  = op_hi_ok && (op_lo == 6'b001101);
`else
    assign is_ori  = 1'b0;
`endif
    assign legal = is_r | is_lw | is_sw | is_beq | is_addi | is_j | is_ori;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:   state_next = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_r)                state_next = S_EXECUTE;
                else if (is_lw || is_sw) state_next = S_MEMADR;
                else if (is_beq)         state_next = S_BRANCH;
                else if (is_addi)        state_next = S_ADDIEX;
                else if (is_j)           state_next = S_JUMP;
                else if (is_ori)         state_next = S_ORIEX;
                else                     state_next = S_FETCH;
            end
            S_MEMADR:  state_next = is_lw ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
`ifdef MC_MAINDEC_ORI_EN
            S_ORIEX:   state_next = S_ADDIWB;
`endif
            default:   state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_FETCH;
            retired <= '0;
        end else begin
            state <= state_next;
            // Illegal ops return from DECODE and are not counted.
            if (state_next == S_FETCH && state != S_FETCH && state != S_DECODE)
                retired <= retired + 1'b1;
        end
    end

    always_comb begin
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        branch       = 1'b0;
        pcwrite_raw  = 1'b0;
        alusrcb      = 2'b00;
        aluop        = 2'b00;
        pcsrc        = 2'b00;
        case (state)
            S_FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = rdy;
                pcwrite_raw = rdy;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = rdy;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_JUMP: begin
                pcsrc       = 2'b10;
                pcwrite_raw = 1'b1;
            end
`ifdef MC_MAINDEC_ORI_EN
            S_ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
            end
`endif
            default: ;
        endcase
    end

    // Write strobes are held off combinationally while reset is asserted.
    assign irwrite    = irwrite_raw  & reset_n;
    assign pcwrite    = pcwrite_raw  & reset_n;
    assign regwrite   = regwrite_raw & reset_n;
    assign memwrite   = memwrite_raw & reset_n;
    assign illegal_op = (state == S_DECODE) && !legal;
    assign state_o    = state;

endmodule

// File: tb/tb_mc_maindec.sv
// Directed bench for mc_maindec: state sequences, per-state controls, wait states, reset abort, counter wrap.
module tb_mc_maindec;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic       alusrca, branch, pcwrite, illegal_op;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state_o;
    logic [3:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;

    mc_maindec #(.OP_W(6), .CNT_W(4), .WAIT_MEM(1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .branch     (branch),
        .pcwrite    (pcwrite),
        .alusrcb    (alusrcb),
        .aluop      (aluop),
        .pcsrc      (pcsrc),
        .illegal_op (illegal_op),
        .state_o    (state_o),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the current state, then advance one clock.
    task automatic st(input string tag, input int exp_st);
        check_eq(tag, {28'd0, state_o}, exp_st);
        tick();
    endtask

    task automatic chk_ret(input string tag);
        check_eq(tag, {28'd0, retired}, exp_ret % 16);
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 6'h00;
        mem_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_state", {28'd0, state_o}, 0);
        check_eq("rst_retired", {28'd0, retired}, 0);
        check_eq("rst_irwrite_forced", {31'd0, irwrite}, 0);
        check_eq("rst_pcwrite_forced", {31'd0, pcwrite}, 0);
        check_eq("rst_illegal", {31'd0, illegal_op}, 0);
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_irwrite", {31'd0, irwrite}, 1);

        // R-type, op ignored outside DECODE/MEMADR
        op = 6'h00;
        check_eq("r_fetch_alusrcb", {30'd0, alusrcb}, 1);
        st("r_s0", 0);
        check_eq("r_dec_alusrcb", {30'd0, alusrcb}, 3);
        check_eq("r_dec_regwrite", {31'd0, regwrite}, 0);
        st("r_s1", 1);
        check_eq("r_ex_aluop", {30'd0, aluop}, 2);
        check_eq("r_ex_alusrca", {31'd0, alusrca}, 1);
        check_eq("r_ex_regwrite", {31'd0, regwrite}, 0);
        op = 6'h23;
        st("r_s6", 6);
        check_eq("r_wb_regwrite", {31'd0, regwrite}, 1);
        check_eq("r_wb_regdst", {31'd0, regdst}, 1);
        st("r_s7", 7);
        exp_ret++;
        check_eq("r_back_fetch", {28'd0, state_o}, 0);
        chk_ret("r_retired");

        // LW with two wait states in MEMRD
        op = 6'h23;
        st("lw_s0", 0);
        st("lw_s1", 1);
        check_eq("lw_adr_alusrcb", {30'd0, alusrcb}, 2);
        mem_ready = 1'b0;
        st("lw_s2", 2);
        check_eq("lw_rd_iord", {31'd0, iord}, 1);
        st("lw_s3a", 3);
        st("lw_s3b", 3);
        mem_ready = 1'b1;
        st("lw_s3c", 3);
        check_eq("lw_wb_memtoreg", {31'd0, memtoreg}, 1);
        check_eq("lw_wb_regwrite", {31'd0, regwrite}, 1);
        check_eq("lw_wb_regdst", {31'd0, regdst}, 0);
        st("lw_s4", 4);
        exp_ret++;
        check_eq("lw_back_fetch", {28'd0, state_o}, 0);
        chk_ret("lw_retired");

        // SW with one wait state
        op = 6'h2B;
        st("sw_s0", 0);
        check_eq("sw_dec_regwrite", {31'd0, regwrite}, 0);
        st("sw_s1", 1);
        st("sw_s2", 2);
        mem_ready = 1'b0;
        #1;
        check_eq("sw_memwrite_wait", {31'd0, memwrite}, 0);
        check_eq("sw_regwrite_wait", {31'd0, regwrite}, 0);
        st("sw_s5a", 5);
        mem_ready = 1'b1;
        #1;
        check_eq("sw_memwrite_ready", {31'd0, memwrite}, 1);
        check_eq("sw_regwrite_ready", {31'd0, regwrite}, 0);
        st("sw_s5b", 5);
        exp_ret++;
        check_eq("sw_memwrite_after", {31'd0, memwrite}, 0);
        check_eq("sw_back_fetch", {28'd0, state_o}, 0);
        chk_ret("sw_retired");

        // Illegal opcode
        op = 6'h3F;
        st("ill_s0", 0);
        check_eq("ill_pulse", {31'd0, illegal_op}, 1);
        check_eq("ill_strobes", {28'd0, irwrite, pcwrite, regwrite, memwrite}, 0);
        st("ill_s1", 1);
        check_eq("ill_back_fetch", {28'd0, state_o}, 0);
        check_eq("ill_pulse_end", {31'd0, illegal_op}, 0);
        chk_ret("ill_retired");

        // BEQ
        op = 6'h04;
        st("beq_s0", 0);
        st("beq_s1", 1);
        check_eq("beq_ctrl", {25'd0, branch, alusrca, pcsrc, aluop, pcwrite}, 7'b1_1_01_01_0);
        st("beq_s8", 8);
        exp_ret++;
        chk_ret("beq_retired");

        // J
        op = 6'h02;
        st("j_s0", 0);
        st("j_s1", 1);
        check_eq("j_ctrl", {27'd0, pcwrite, pcsrc, branch, regwrite}, 5'b1_10_0_0);
        st("j_s11", 11);
        exp_ret++;
        chk_ret("j_retired");

        // ADDI
        op = 6'h08;
        st("addi_s0", 0);
        st("addi_s1", 1);
        check_eq("addi_ex", {27'd0, alusrca, alusrcb, aluop}, 5'b1_10_00);
        st("addi_s9", 9);
        check_eq("addi_wb", {29'd0, regwrite, regdst, memtoreg}, 3'b100);
        st("addi_s10", 10);
        exp_ret++;
        chk_ret("addi_retired");

        // ORI: legal only with the optional feature
        op = 6'h0D;
        st("ori_s0", 0);
`ifdef MC_MAINDEC_ORI_EN
        check_eq("ori_not_illegal", {31'd0, illegal_op}, 0);
        st("ori_s1", 1);
        check_eq("ori_aluop", {30'd0, aluop}, 3);
        st("ori_s12", 12);
        check_eq("ori_wb_regwrite", {31'd0, regwrite}, 1);
        st("ori_s10", 10);
        exp_ret++;
`else
        check_eq("ori_illegal", {31'd0, illegal_op}, 1);
        st("ori_s1", 1);
`endif
        check_eq("ori_back_fetch", {28'd0, state_o}, 0);
        chk_ret("ori_retired");

        // Reset asserted mid-MEMRD aborts without writeback
        op = 6'h23;
        st("abort_s0", 0);
        st("abort_s1", 1);
        mem_ready = 1'b0;
        st("abort_s2", 2);
        check_eq("abort_in_memrd", {28'd0, state_o}, 3);
        #2;
        reset_n = 1'b0;
        #1;
        exp_ret = 0;
        check_eq("abort_state", {28'd0, state_o}, 0);
        chk_ret("abort_retired");
        check_eq("abort_regwrite", {31'd0, regwrite}, 0);
        mem_ready = 1'b1;
        tick();
        check_eq("abort_hold_regwrite", {31'd0, regwrite}, 0);
        check_eq("abort_hold_irwrite", {31'd0, irwrite}, 0);
        reset_n = 1'b1;
        #1;
        check_eq("abort_rel_irwrite", {31'd0, irwrite}, 1);
        check_eq("abort_rel_regwrite", {31'd0, regwrite}, 0);
        st("abort_rel_s0", 0);
        st("abort_lw_s1", 1);
        st("abort_lw_s2", 2);
        st("abort_lw_s3", 3);
        st("abort_lw_s4", 4);
        exp_ret++;
        chk_ret("abort_lw_retired");

        // 16 BEQs wrap the 4-bit counter through 15 -> 0
        op = 6'h04;
        for (int i = 0; i < 16; i++) begin
            st("wrap_s0", 0);
            st("wrap_s1", 1);
            st("wrap_s8", 8);
            exp_ret++;
            chk_ret("wrap_retired");
        end
        check_eq("wrap_final", {28'd0, retired}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
